// File: rtl/mips_encode_if.sv
// Request/response bundle between an instruction producer and mips_encode.
// master drives requests and consumes words; slave is the encoder side.
interface mips_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/mips_encode.sv
// Encodes assembler-level requests into MIPS words with sequential byte addresses.
// Latency 1 cycle from accept to out_valid; LI with a nonzero upper half emits two words.
// Output stalls hold the word and drop in_ready; a full pipe streams one word per cycle.
module mips_encode (
  input  logic         clock,
  input  logic         reset,
  mips_encode_if.slave bus
);

  typedef enum logic {S_RUN = 1'b0, S_LI2 = 1'b1} state_t;

  localparam logic [31:0] BASE_ADDR = 32'h0040_0000;

  state_t      state_q, state_d;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [31:0] out_addr_q;
  logic [31:0] pend_q;

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] enc_word;
  logic [31:0] enc_pend;
  logic        enc_two;
  logic [5:0]  funct;

  assign out_xfer = out_valid_q && bus.out_ready;
  assign in_xfer  = bus.in_valid && bus.in_ready;

  always_comb begin
    funct = 6'h20;
    case (bus.in_op)
      4'd0:    funct = 6'h20;
      4'd1:    funct = 6'h22;
      4'd2:    funct = 6'h24;
      4'd3:    funct = 6'h25;
      4'd4:    funct = 6'h27;
      4'd5:    funct = 6'h26;
      4'd6:    funct = 6'h2A;
      default: funct = 6'h20;
    endcase
  end

  always_comb begin
    enc_word = 32'h0;
    enc_pend = 32'h0;
    enc_two  = 1'b0;
    case (bus.in_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
        enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, funct};
      4'd7:  enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd8:  enc_word = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd9:  enc_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd10: enc_word = {6'h0E, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd11: enc_word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      4'd12: enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd13: enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd14: enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      default: begin
        // LI: small constants fit one ORI off $0, otherwise LUI then ORI into rt
        if (bus.in_imm[31:16] != 16'h0) begin
          enc_two  = 1'b1;
          enc_word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm[31:16]};
          enc_pend = {6'h0D, bus.in_rt, bus.in_rt, bus.in_imm[15:0]};
        end else begin
          enc_word = {6'h0D, 5'd0, bus.in_rt, bus.in_imm[15:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (in_xfer && enc_two) state_d = S_LI2;
      S_LI2:   if (out_xfer) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    bus.in_ready = !reset && (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      pend_q      <= 32'h0;
    end else begin
      if (out_xfer) out_addr_q <= out_addr_q + 32'd4;
      if (state_q == S_LI2 && out_xfer) begin
        out_inst_q <= pend_q;
      end else if (in_xfer) begin
        out_inst_q  <= enc_word;
        out_valid_q <= 1'b1;
        if (enc_two) pend_q <= enc_pend;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: hand-computed words, addresses and handshake levels.
module tb_mips_encode;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mips_encode_if bus ();

  mips_encode dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [31:0] vec_exp [15];

  initial begin
    checks = 0;
    errors = 0;
    vec_exp = '{32'h00853020, 32'h00853022, 32'h00853024, 32'h00853025, 32'h00853027,
                32'h00853026, 32'h0085302A, 32'h20858001, 32'h30858001, 32'h34858001,
                32'h38858001, 32'h3C058001, 32'h8C858001, 32'hAC858001, 32'h10858001};

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = 4'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_imm    = 32'h0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_addr", bus.out_addr, 32'h0040_0000);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // single ADD, one cycle latency
    req(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_inst", bus.out_inst, 32'h00221820);
    chk("add_addr", bus.out_addr, 32'h0040_0000);
    step();
    chk("add_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("add_drain_addr", bus.out_addr, 32'h0040_0004);

    // ADDI then SW back to back
    do_reset();
    req(4'd7, 5'd0, 5'd8, 5'd0, 32'h0000_0005);
    step();
    chk("addi_inst", bus.out_inst, 32'h20080005);
    chk("addi_addr", bus.out_addr, 32'h0040_0000);
    req(4'd13, 5'd29, 5'd8, 5'd0, 32'h0000_0004);
    #1;
    chk("sw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("sw_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("sw_inst", bus.out_inst, 32'hAFA80004);
    chk("sw_addr", bus.out_addr, 32'h0040_0004);
    step();
    chk("sw_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // two-word LI, in_ready low while the ORI is pending
    do_reset();
    req(4'd15, 5'd0, 5'd9, 5'd0, 32'h1234_5678);
    step();
    req(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    #1;
    chk("li2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("li_lui_inst", bus.out_inst, 32'h3C091234);
    chk("li_lui_addr", bus.out_addr, 32'h0040_0000);
    step();
    bus.in_valid = 1'b0;
    chk("li_ori_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("li_ori_inst", bus.out_inst, 32'h35295678);
    chk("li_ori_addr", bus.out_addr, 32'h0040_0004);
    step();
    chk("li_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("li_drain_addr", bus.out_addr, 32'h0040_0008);

    // one-word LI, next request accepted immediately
    do_reset();
    req(4'd15, 5'd0, 5'd9, 5'd0, 32'h0000_ABCD);
    step();
    chk("li1_inst", bus.out_inst, 32'h3409ABCD);
    chk("li1_addr", bus.out_addr, 32'h0040_0000);
    req(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    #1;
    chk("li1_next_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("li1_next_inst", bus.out_inst, 32'h00221820);
    chk("li1_next_addr", bus.out_addr, 32'h0040_0004);

    // output stall for three cycles
    bus.out_ready = 1'b0;
    req(4'd3, 5'd7, 5'd7, 5'd7, 32'h0);
    #1;
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_inst", bus.out_inst, 32'h00221820);
      chk("stall_addr", bus.out_addr, 32'h0040_0004);
      chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_addr", bus.out_addr, 32'h0040_0008);

    // every remaining opcode, streamed at one word per cycle
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req(4'(i), 5'd4, 5'd5, 5'd6, 32'hFFFF_8001);
      step();
      chk($sformatf("stream_inst_op%0d", i), bus.out_inst, vec_exp[i]);
      chk($sformatf("stream_addr_op%0d", i), bus.out_addr, 32'h0040_0000 + 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // reset while the LUI half of an LI is stalled
    do_reset();
    bus.out_ready = 1'b0;
    req(4'd15, 5'd0, 5'd9, 5'd0, 32'h1234_5678);
    step();
    bus.in_valid = 1'b0;
    chk("rli_lui_inst", bus.out_inst, 32'h3C091234);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rli_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b0;
    chk("rli_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rli_addr", bus.out_addr, 32'h0040_0000);
    chk("rli_inst", bus.out_inst, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rli_no_ori", {31'd0, bus.out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_encode.md
MIPS_ENCODE -- requirements
Module: mips_encode

Interface
REQ-001 SHALL: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL: in_valid  input  1  request present on in_op/in_rs/in_rt/in_rd/in_imm.
REQ-004 SHALL: in_ready  output  1  encoder accepts request this cycle; transfer = in_valid && in_ready.
REQ-005 SHALL: in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLT, 7 ADDI, 8 ANDI, 9 ORI, 10 XORI, 11 LUI, 12 LW, 13 SW, 14 BEQ, 15 LI (pseudo).
REQ-006 SHALL: in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-007 SHALL: in_imm  input  32  immediate; bits [15:0] used except by LI, which uses all 32.
REQ-008 SHALL: out_valid  output  1  out_inst/out_addr hold a word.
REQ-009 SHALL: out_ready  input  1  consumer takes word; transfer = out_valid && out_ready.
REQ-010 SHALL: out_inst  output  32  encoded MIPS instruction word.
REQ-011 SHALL: out_addr  output  32  byte address of out_inst.

Function
REQ-012 SHALL: R-type (ops 0-6): opcode 0x00, rs, rt, rd, shamt 0; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A.
REQ-013 SHALL: I-type {opcode, rs, rt, in_imm[15:0]}; opcodes ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F (rs forced 0), LW 0x23, SW 0x2B, BEQ 0x04; in_rd ignored.
REQ-014 SHALL: BEQ imm passed through unmodified (caller supplies word offset).
REQ-015 SHALL: LI with in_imm[31:16] != 0 expands to two words: LUI rt,imm[31:16] then ORI rt,rt,imm[15:0], emitted in that order at consecutive addresses.
REQ-016 SHALL: LI with in_imm[31:16] == 0 emits single word ORI rt,$0,imm[15:0].
REQ-017 SHALL: FSM states S_RUN and S_LI2; S_LI2 holds pending ORI word while LUI word awaits transfer.
REQ-018 SHALL: in_ready = (state == S_RUN) && (!out_valid || out_ready); combinational.
REQ-019 SHALL: input transfer loads out_inst in the following cycle (latency 1) and sets out_valid; two-word LI additionally moves S_RUN -> S_LI2.
REQ-020 SHALL: in S_LI2, on output transfer, load pending ORI word, keep out_valid=1, return to S_RUN.
REQ-021 SHALL: output transfer with no new word loaded clears out_valid.
REQ-022 SHALL: simultaneous output transfer and input transfer in S_RUN replace word in same cycle; sustained throughput 1 word/cycle, no bubble.
REQ-023 SHALL: out_inst and out_addr held stable while out_valid && !out_ready.
REQ-024 SHALL: out_addr increments by 4 on every output transfer, wraps 0xFFFFFFFC -> 0x00000000.
REQ-025 SHALL: all in_op values legal; no error output.

Reset
REQ-026 SHALL: reset gives out_valid=0, out_inst=0x00000000, out_addr=0x00400000, state S_RUN.
REQ-027 SHALL: reset mid-LI (S_LI2) discards pending ORI word; no partial emission after reset.
REQ-028 SHALL: reset overrides simultaneous in/out transfers; in_ready=0 while reset high.

Verification
REQ-029 SHALL: ADD rs=1 rt=2 rd=3, out_ready=1 -> out_inst 0x00221820 at 0x00400000, one cycle after accept.
REQ-030 SHALL: ADDI rs=0 rt=8 imm=0x0005 then SW rs=29 rt=8 imm=0x0004 back-to-back -> 0x20080005 @0x00400000, 0xAFA80004 @0x00400004, no bubble.
REQ-031 SHALL: LI rt=9 imm=0x12345678 -> 0x3C091234 @0x00400000 then 0x35295678 @0x00400004; in_ready=0 while in S_LI2.
REQ-032 SHALL: LI rt=9 imm=0x0000ABCD -> single word 0x3409ABCD; next request accepted immediately.
REQ-033 SHALL: out_ready=0 for 3 cycles with word held -> out_inst/out_addr unchanged, in_ready=0; release -> single transfer, out_addr +4.
REQ-034 SHALL: reset asserted while LUI word of LI pending -> next cycle out_valid=0, out_addr=0x00400000, ORI word never emitted.
